// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST sequencer.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;

  // Truth tables indexed by {B,A}.
  localparam logic [3:0] EXP_AND  = 4'b1000;
  localparam logic [3:0] EXP_OR   = 4'b1110;
  localparam logic [3:0] EXP_XOR  = 4'b0110;
  localparam logic [3:0] EXP_NAND = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags zero; holds at zero instead of wrapping.
module settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks a 2-input gate through all four input vectors,
// compares the sampled output with EXPECTED and reports pass/fail_mask.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] EXPECTED      = EXP_AND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic       a_o,
  output logic       b_o,
  input  logic       q_i
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       LAST_IDX = 2'(NUM_VECTORS - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_bist_ctrl: SETTLE_CYCLES must be at least 1");
  end

  state_t     state;
  state_t     state_next;
  logic [1:0] idx;
  logic [1:0] idx_next;
  logic [3:0] fail_mask_next;
  logic       accept;
  logic       timer_load;
  logic       timer_dec;
  logic       timer_zero;
  logic       drive_next;

  settle_timer #(
    .WIDTH(CNT_W)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(RELOAD),
    .dec       (timer_dec),
    .zero      (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (timer_zero) state_next = SAMPLE;
      SAMPLE:  state_next = (idx == LAST_IDX) ? DONE : SETTLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == IDLE) && start;
    busy       = (state == SETTLE) || (state == SAMPLE);
    done       = (state == DONE);
    timer_load = accept || ((state == SAMPLE) && (idx != LAST_IDX));
    timer_dec  = (state == SETTLE);
  end

  always_comb begin
    idx_next       = idx;
    fail_mask_next = fail_mask;
    if (accept) begin
      idx_next       = '0;
      fail_mask_next = '0;
    end else if (state == SAMPLE) begin
      if (q_i != EXPECTED[idx]) fail_mask_next[idx] = 1'b1;
      if (idx != LAST_IDX) idx_next = idx + 2'd1;
    end
  end

  assign drive_next = (state_next == SETTLE) || (state_next == SAMPLE);

  // pass is resolved on the edge into DONE so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
    end else begin
      idx       <= idx_next;
      fail_mask <= fail_mask_next;
      if (accept) begin
        pass <= 1'b0;
      end else if ((state == SAMPLE) && (idx == LAST_IDX)) begin
        pass <= (fail_mask_next == 4'b0000);
      end
      a_o <= drive_next ? idx_next[0] : 1'b0;
      b_o <= drive_next ? idx_next[1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl using three instances with different settle/expected settings.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  logic       clk;
  logic       rst       [3];
  logic       start     [3];
  logic [3:0] tt        [3];
  logic       busy      [3];
  logic       done      [3];
  logic       pass      [3];
  logic [3:0] fail_mask [3];
  logic       a_o       [3];
  logic       b_o       [3];
  logic       q_i       [3];

  int vectors;
  int miscompares;

  typedef struct {
    int         d;
    logic [3:0] tbl;
    logic [3:0] mask;
    logic       ok;
  } vec_t;

  vec_t vecs [7];

  // Each gate model is a truth table indexed by {B,A}.
  assign q_i[0] = tt[0][{b_o[0], a_o[0]}];
  assign q_i[1] = tt[1][{b_o[1], a_o[1]}];
  assign q_i[2] = tt[2][{b_o[2], a_o[2]}];

  gate_bist_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(EXP_AND)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .fail_mask(fail_mask[0]), .a_o(a_o[0]), .b_o(b_o[0]), .q_i(q_i[0])
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(EXP_OR)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .fail_mask(fail_mask[1]), .a_o(a_o[1]), .b_o(b_o[1]), .q_i(q_i[1])
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(3), .EXPECTED(EXP_AND)) dut2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .fail_mask(fail_mask[2]), .a_o(a_o[2]), .b_o(b_o[2]), .q_i(q_i[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int s_of(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  function automatic logic [3:0] exp_of(input int d);
    return (d == 1) ? EXP_OR : EXP_AND;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // One complete run checked cycle by cycle from the spec's timing rules.
  task automatic run_check(input int d, input logic [3:0] tbl, input logic [3:0] exp_mask,
                           input logic exp_pass, input bit noisy);
    int s;
    int busy_len;
    int k;
    s        = s_of(d);
    busy_len = 4 * (s + 1);
    tt[d]    = tbl;
    @(negedge clk);
    start[d] = 1'b1;
    for (int c = 1; c <= busy_len + 2; c++) begin
      @(negedge clk);
      if (c <= busy_len) begin
        k = (c - 1) / (s + 1);
        check($sformatf("d%0d c%0d drive", d, c),
              {5'b0, busy[d], done[d], a_o[d], b_o[d]},
              {5'b0, 1'b1, 1'b0, k[0], k[1]});
        if (c == 1)
          check($sformatf("d%0d cleared on start", d),
                {4'b0, pass[d], fail_mask[d]}, 9'b0);
      end else if (c == busy_len + 1) begin
        check($sformatf("d%0d done cycle", d),
              {2'b0, busy[d], done[d], a_o[d], pass[d], fail_mask[d]},
              {2'b0, 1'b0, 1'b1, 1'b0, exp_pass, exp_mask});
      end else begin
        check($sformatf("d%0d idle hold", d),
              {1'b0, busy[d], done[d], a_o[d], b_o[d], pass[d], fail_mask[d]},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_pass, exp_mask});
      end
      start[d] = (noisy && c <= busy_len + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start[d] = 1'b0;
  endtask

  initial begin
    int         d;
    int         ph;
    int         k;
    int         wcount;
    bit         seen;
    logic [3:0] tbl;
    logic [3:0] m;

    vectors     = 0;
    miscompares = 0;

    vecs[0] = '{0, 4'b1000, 4'b0000, 1'b1};
    vecs[1] = '{0, 4'b1111, 4'b0111, 1'b0};
    vecs[2] = '{0, 4'b1110, 4'b0110, 1'b0};
    vecs[3] = '{1, 4'b1000, 4'b0110, 1'b0};
    vecs[4] = '{1, 4'b1110, 4'b0000, 1'b1};
    vecs[5] = '{2, 4'b0110, 4'b1110, 1'b0};
    vecs[6] = '{2, 4'b1000, 4'b0000, 1'b1};

    for (int i = 0; i < 3; i++) begin
      rst[i]   = 1'b1;
      start[i] = 1'b0;
      tt[i]    = EXP_AND;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d reset state", i),
            {1'b0, busy[i], done[i], a_o[i], b_o[i], pass[i], fail_mask[i]}, 9'b0);
      rst[i] = 1'b0;
    end

    for (int i = 0; i < 7; i++)
      run_check(vecs[i].d, vecs[i].tbl, vecs[i].mask, vecs[i].ok, 1'b0);

    for (int r = 0; r < 12; r++) begin
      d   = $urandom_range(0, 2);
      tbl = 4'($urandom);
      m   = tbl ^ exp_of(d);
      run_check(d, tbl, m, (m == 4'b0000), 1'b1);
    end

    // Start held high: back-to-back runs with one IDLE cycle between them.
    tt[2] = EXP_AND;
    @(negedge clk);
    start[2] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      ph = (c - 1) % 18;
      k  = ph / 4;
      check($sformatf("hold c%0d", c),
            {5'b0, busy[2], done[2], a_o[2], b_o[2]},
            {5'b0, (ph < 16), (ph == 16), (ph < 16) ? k[0] : 1'b0, (ph < 16) ? k[1] : 1'b0});
    end
    start[2] = 1'b0;
    wcount   = 0;
    seen     = 1'b0;
    while (!seen && wcount < 60) begin
      @(negedge clk);
      wcount++;
      seen = done[2];
    end
    check("hold tail to done", 9'(wcount), 9'd13);
    @(negedge clk);
    check("hold no requeue", {7'b0, busy[2], done[2]}, 9'b0);

    // Reset in the SETTLE of vector 2 aborts without a done pulse.
    tt[0] = 4'b1111;
    @(negedge clk);
    start[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    check("pre-reset vector 2",
          {1'b0, busy[0], a_o[0], b_o[0], 1'b0, fail_mask[0]},
          {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011});
    rst[0] = 1'b1;
    @(negedge clk);
    check("post-reset state",
          {1'b0, busy[0], done[0], a_o[0], b_o[0], pass[0], fail_mask[0]}, 9'b0);
    rst[0] = 1'b0;
    seen   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen = 1'b1;
    end
    check("no done after abort", {8'b0, seen}, 9'b0);
    run_check(0, EXP_AND, 4'b0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
